// File: rtl/alu_controller_unit_pkg.sv
// Shared encodings for the ALU control path: instruction classes, R-type function codes, ALU op selects.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_ctrl_pkg;

    // Instruction class driven by the main controller.
    localparam logic [1:0] MTYPE = 2'b00;  // lw/sw: address calculation
    localparam logic [1:0] BTYPE = 2'b01;  // beq/bne: compare by subtraction
    localparam logic [1:0] RTYPE = 2'b10;  // R-type, plus addi/andi via substituted func
    localparam logic [1:0] JTYPE = 2'b11;  // jumps: ALU result is unused

    // R-type function field values understood by the decoder.
    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_XOR  = 6'b100110;
    localparam logic [5:0] FUNC_NOR  = 6'b100111;
    localparam logic [5:0] FUNC_SLT  = 6'b101010;
    localparam logic [5:0] FUNC_SLTU = 6'b101011;

    // Operation select presented to the ALU.
    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_XOR  = 3'b011,
        OP_NOR  = 3'b100,
        OP_SLTU = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } alu_sel_t;

    // Value held by the output register while in reset.
    localparam alu_sel_t RESET_OP = OP_ADD;

endpackage : alu_ctrl_pkg

// File: rtl/alu_controller_unit_if.sv
// Bundle between the main controller side and the ALU control unit: class/func in, op select/illegal out.
// Latency: n/a (wires only).
// Backpressure: none; the consumer samples every cycle.
interface alu_controller_unit_if;
    import alu_ctrl_pkg::*;

    logic [1:0] alu_op;         // instruction class
    logic [5:0] func;           // R-type function field
    alu_sel_t   alu_operation;  // registered ALU op select
    logic       illegal;        // registered unsupported-func flag

    // Driver of the decode request (main controller / testbench).
    modport master (
        output alu_op,
        output func,
        input  alu_operation,
        input  illegal
    );

    // The ALU control unit itself.
    modport slave (
        input  alu_op,
        input  func,
        output alu_operation,
        output illegal
    );

endinterface : alu_controller_unit_if

// File: rtl/alu_controller_unit_func_decode.sv
// Combinational R-type function decoder: func -> {ALU op select, illegal}; ALU_CTRL_EXT_OPS_EN adds XOR/NOR/SLTU.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu_func_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] func_i,
    output alu_sel_t   op_o,
    output logic       illegal_o
);

    // Map each supported function code to its op; anything else falls back to ADD and is flagged.
    always_comb begin
        op_o      = OP_ADD;
        illegal_o = 1'b0;
        case (func_i)
            FUNC_ADD: op_o = OP_ADD;
            FUNC_SUB: op_o = OP_SUB;
            FUNC_AND: op_o = OP_AND;
            FUNC_OR:  op_o = OP_OR;
            FUNC_SLT: op_o = OP_SLT;
`ifdef ALU_CTRL_EXT_OPS_EN
            FUNC_XOR:  op_o = OP_XOR;
            FUNC_NOR:  op_o = OP_NOR;
            FUNC_SLTU: op_o = OP_SLTU;
`else
            // Extended codes are recognised by name but unsupported in this build.
            FUNC_XOR, FUNC_NOR, FUNC_SLTU: begin
                op_o      = OP_ADD;
                illegal_o = 1'b1;
            end
`endif
            default: begin
                op_o      = OP_ADD;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule : alu_func_decode

// File: rtl/alu_controller_unit.sv
// Second-level MIPS ALU decoder: alu_op class + func -> registered 3-bit ALU op and illegal flag (ALU_CTRL_EXT_OPS_EN enables XOR/NOR/SLTU).
// Latency: 1 cycle; inputs sampled at edge N are visible on the outputs after edge N.
// Backpressure: none; accepts a new decode every cycle, no stall input. Synchronous active-low reset forces ADD/0.
module alu_controller_unit
    import alu_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    alu_controller_unit_if.slave        bus
);

    alu_sel_t dec_op;
    logic     dec_illegal;

    alu_sel_t op_d;
    alu_sel_t op_q;
    logic     illegal_d;
    logic     illegal_q;

    alu_func_decode u_func_decode (
        .func_i    (bus.func),
        .op_o      (dec_op),
        .illegal_o (dec_illegal)
    );

    // Class mux: only R-type consults func; every other class has a fixed op and is never illegal.
    always_comb begin
        op_d      = OP_ADD;
        illegal_d = 1'b0;
        case (bus.alu_op)
            MTYPE: op_d = OP_ADD;
            BTYPE: op_d = OP_SUB;
            RTYPE: begin
                op_d      = dec_op;
                illegal_d = dec_illegal;
            end
            JTYPE: op_d = OP_ADD;
            default: begin
                op_d      = OP_ADD;
                illegal_d = 1'b0;
            end
        endcase
    end

    // Single output register stage; reset wins over any input and drops the pending decode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q      <= RESET_OP;
            illegal_q <= 1'b0;
        end else begin
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.alu_operation = op_q;
    assign bus.illegal       = illegal_q;

endmodule : alu_controller_unit

// File: tb/tb_alu_controller_unit.sv
// Directed testbench for alu_controller_unit with hand-computed expectations.
// Latency: checks each result one edge after its inputs are applied.
// Backpressure: n/a; stimulus is applied every cycle.
module tb_alu_controller_unit;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    alu_controller_unit_if bus ();

    alu_controller_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two edges with an R-type SUB pending on the inputs.
    task automatic test_reset();
        rst        = 1'b0;
        bus.alu_op = 2'b10;
        bus.func   = 6'b100010;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (bus.alu_operation !== 3'b010)
                $display("FAIL reset_op[%0d]: got %b expected 010", i, bus.alu_operation);
            else pass_cnt++;
            total_cnt++;
            if (bus.illegal !== 1'b0)
                $display("FAIL reset_illegal[%0d]: got %b expected 0", i, bus.illegal);
            else pass_cnt++;
        end
        rst = 1'b1;
    endtask

    // Non-R classes: memory, branch, jump; func set to an unsupported value to prove it is ignored.
    task automatic test_class_decode();
        logic [1:0] ops [3];
        logic [2:0] exp [3];
        ops[0] = 2'b00; exp[0] = 3'b010;
        ops[1] = 2'b01; exp[1] = 3'b110;
        ops[2] = 2'b11; exp[2] = 3'b010;
        for (int i = 0; i < 3; i++) begin
            bus.alu_op = ops[i];
            bus.func   = 6'b000000;
            @(posedge clk); #1;
            total_cnt++;
            if (bus.alu_operation !== exp[i])
                $display("FAIL class_op alu_op=%b: got %b expected %b", ops[i], bus.alu_operation, exp[i]);
            else pass_cnt++;
            total_cnt++;
            if (bus.illegal !== 1'b0)
                $display("FAIL class_illegal alu_op=%b: got %b expected 0", ops[i], bus.illegal);
            else pass_cnt++;
        end
    endtask

    // Supported R-type functions on consecutive cycles.
    task automatic test_rtype_sweep();
        logic [5:0] fn  [5];
        logic [2:0] exp [5];
        fn[0] = 6'b100000; exp[0] = 3'b010;
        fn[1] = 6'b100010; exp[1] = 3'b110;
        fn[2] = 6'b100100; exp[2] = 3'b000;
        fn[3] = 6'b100101; exp[3] = 3'b001;
        fn[4] = 6'b101010; exp[4] = 3'b111;
        bus.alu_op = 2'b10;
        for (int i = 0; i < 5; i++) begin
            bus.func = fn[i];
            @(posedge clk); #1;
            total_cnt++;
            if (bus.alu_operation !== exp[i])
                $display("FAIL rtype_op func=%b: got %b expected %b", fn[i], bus.alu_operation, exp[i]);
            else pass_cnt++;
            total_cnt++;
            if (bus.illegal !== 1'b0)
                $display("FAIL rtype_illegal func=%b: got %b expected 0", fn[i], bus.illegal);
            else pass_cnt++;
        end
    endtask

    // Unsupported func flags illegal; the following branch clears it.
    task automatic test_unsupported();
        bus.alu_op = 2'b10;
        bus.func   = 6'b000000;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.alu_operation !== 3'b010)
            $display("FAIL unsup_op: got %b expected 010", bus.alu_operation);
        else pass_cnt++;
        total_cnt++;
        if (bus.illegal !== 1'b1)
            $display("FAIL unsup_illegal: got %b expected 1", bus.illegal);
        else pass_cnt++;
        bus.alu_op = 2'b01;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.alu_operation !== 3'b110)
            $display("FAIL after_unsup_op: got %b expected 110", bus.alu_operation);
        else pass_cnt++;
        total_cnt++;
        if (bus.illegal !== 1'b0)
            $display("FAIL after_unsup_illegal: got %b expected 0", bus.illegal);
        else pass_cnt++;
    endtask

    // Extended NOR code: decoded only when the extension is built in.
    task automatic test_config();
        logic [2:0] exp_op;
        logic       exp_ill;
`ifdef ALU_CTRL_EXT_OPS_EN
        exp_op  = 3'b100;
        exp_ill = 1'b0;
`else
        exp_op  = 3'b010;
        exp_ill = 1'b1;
`endif
        bus.alu_op = 2'b10;
        bus.func   = 6'b100111;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.alu_operation !== exp_op)
            $display("FAIL config_op: got %b expected %b", bus.alu_operation, exp_op);
        else pass_cnt++;
        total_cnt++;
        if (bus.illegal !== exp_ill)
            $display("FAIL config_illegal: got %b expected %b", bus.illegal, exp_ill);
        else pass_cnt++;
    endtask

    // Inputs changed between edges must not reach the outputs until the next edge.
    task automatic test_between_edges();
        bus.alu_op = 2'b01;
        bus.func   = 6'b100000;
        @(posedge clk); #1;
        #2;
        bus.alu_op = 2'b10;
        bus.func   = 6'b000000;
        #1;
        total_cnt++;
        if (bus.alu_operation !== 3'b110 || bus.illegal !== 1'b0)
            $display("FAIL hold_between_edges: got %b/%b expected 110/0", bus.alu_operation, bus.illegal);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.alu_operation !== 3'b010 || bus.illegal !== 1'b1)
            $display("FAIL next_edge_update: got %b/%b expected 010/1", bus.alu_operation, bus.illegal);
        else pass_cnt++;
    endtask

    // Reset dropped for one edge mid-stream discards the decode; first valid result one edge after release.
    task automatic test_midstream_reset();
        bus.alu_op = 2'b10;
        bus.func   = 6'b100010;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.alu_operation !== 3'b110)
            $display("FAIL stream_pre_reset: got %b expected 110", bus.alu_operation);
        else pass_cnt++;
        rst      = 1'b0;
        bus.func = 6'b101010;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.alu_operation !== 3'b010 || bus.illegal !== 1'b0)
            $display("FAIL midreset_out: got %b/%b expected 010/0", bus.alu_operation, bus.illegal);
        else pass_cnt++;
        rst      = 1'b1;
        bus.func = 6'b100101;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.alu_operation !== 3'b001 || bus.illegal !== 1'b0)
            $display("FAIL post_release: got %b/%b expected 001/0", bus.alu_operation, bus.illegal);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        rst        = 1'b0;
        bus.alu_op = 2'b00;
        bus.func   = 6'b000000;
        test_reset();
        test_class_decode();
        test_rtype_sweep();
        test_unsupported();
        test_config();
        test_between_edges();
        test_midstream_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_alu_controller_unit
